// File: rtl/ensemble_vote_combiner_pkg.sv
// Shared types and result-word layout for the ensemble majority-vote combiner.
// Imported by the interface, the popcount sub-module and the top.
package ensemble_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int LABEL_BITS    = 8;
  localparam int CLS_LSB       = 0;
  localparam int CNT_LSB       = 16;
  localparam int CNT_BITS      = 4;
  localparam int NOVALID_BIT   = 30;
  localparam int UNANIMOUS_BIT = 31;

  // Build the fused result word; a zero count leaves best_cls at 0, so no_valid implies class 0.
  function automatic logic [31:0] pack_result(
    input logic [LABEL_BITS-1:0] cls,
    input logic [CNT_BITS-1:0]   cnt,
    input logic [CNT_BITS-1:0]   n_voters
  );
    logic [31:0] word;
    word                           = 32'd0;
    word[CLS_LSB +: LABEL_BITS]    = cls;
    word[CNT_LSB +: CNT_BITS]      = cnt;
    word[NOVALID_BIT]              = (cnt == 4'd0);
    word[UNANIMOUS_BIT]            = (cnt == n_voters);
    return word;
  endfunction

endpackage

// File: rtl/ensemble_vote_combiner_if.sv
// Label-input and fused-result AXI-Stream bundle for the vote combiner.
// slave is the combiner's view, master is the view of whatever drives it.
interface ensemble_vote_combiner_if #(
  parameter int N_CLASSIFIERS = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = 4
);
  logic [N_CLASSIFIERS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [N_CLASSIFIERS-1:0]            s_axis_tvalid;
  logic [N_CLASSIFIERS-1:0]            s_axis_tready;
  logic [N_CLASSIFIERS-1:0]            s_axis_tlast;
  logic [DATA_WIDTH-1:0]               m_axis_tdata;
  logic [KEEP_WIDTH-1:0]               m_axis_tkeep;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic                                m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/ensemble_vote_combiner_vote_popcount.sv
// Counts how many captured labels equal the class currently being swept.
// Labels outside the legal class range simply never match.
module vote_popcount
  import ensemble_pkg::*;
#(
  parameter int N_LABELS = 3,
  parameter int CNT_W    = 2
) (
  input  logic [N_LABELS*LABEL_BITS-1:0] labels,
  input  logic [LABEL_BITS-1:0]          cls,
  output logic [CNT_W-1:0]               count
);

  // Match count across all channels for class cls.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_LABELS; i++) begin
      if (labels[i*LABEL_BITS +: LABEL_BITS] == cls) begin
        count = count + CNT_W'(1);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/ensemble_vote_combiner.sv
// Majority-vote combiner: collects one label per classifier channel, sweeps the classes
// one per cycle to find the most-voted one (ties go to the lowest index), emits one result.
module ensemble_vote_combiner
  import ensemble_pkg::*;
#(
  parameter int N_CLASSIFIERS = 3,
  parameter int NUM_CLASSES   = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ensemble_vote_combiner_if.slave axis,
  output logic [31:0]             result_count,
  output logic [31:0]             disagree_count
);

  localparam int                    CW       = $clog2(N_CLASSIFIERS + 1);
  localparam logic [LABEL_BITS-1:0] LAST_K   = LABEL_BITS'(NUM_CLASSES - 1);
  localparam logic [CNT_BITS-1:0]   N_VOTERS = CNT_BITS'(N_CLASSIFIERS);

  state_t                              state_r;
  logic [N_CLASSIFIERS-1:0]            captured_r;
  logic [N_CLASSIFIERS-1:0]            hs_s;
  logic [N_CLASSIFIERS-1:0]            captured_next_s;
  logic [N_CLASSIFIERS*LABEL_BITS-1:0] lbl_r;
  logic [LABEL_BITS-1:0]               k_r;
  logic [LABEL_BITS-1:0]               best_cls_r;
  logic [LABEL_BITS-1:0]               best_cls_next_s;
  logic [CW-1:0]                       best_cnt_r;
  logic [CW-1:0]                       best_cnt_next_s;
  logic [CW-1:0]                       match_cnt_s;
  logic [DATA_WIDTH-1:0]               tdata_r;
  logic                                tvalid_r;
  logic                                out_hs_s;
  logic [31:0]                         result_count_r;
  logic [31:0]                         disagree_count_r;
  logic                                unused_s;

  assign axis.s_axis_tready = (state_r == COLLECT) ? ~captured_r : '0;
  assign axis.m_axis_tdata  = tdata_r;
  assign axis.m_axis_tvalid = tvalid_r;
  assign axis.m_axis_tlast  = tvalid_r;
  assign axis.m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
  assign result_count       = result_count_r;
  assign disagree_count     = disagree_count_r;

  assign hs_s            = axis.s_axis_tvalid & axis.s_axis_tready;
  assign captured_next_s = captured_r | hs_s;
  assign out_hs_s        = (state_r == OUTPUT) && tvalid_r && axis.m_axis_tready;
  // Only label bits [7:0] matter; tlast and the upper data bits are deliberately dropped.
  assign unused_s        = ^{axis.s_axis_tlast, axis.s_axis_tdata};

  vote_popcount #(
    .N_LABELS (N_CLASSIFIERS),
    .CNT_W    (CW)
  ) u_popcount (
    .labels (lbl_r),
    .cls    (k_r),
    .count  (match_cnt_s)
  );

  // Running best; strict compare keeps the earliest (lowest) class on a tie.
  always_comb begin
    best_cnt_next_s = best_cnt_r;
    best_cls_next_s = best_cls_r;
    if (match_cnt_s > best_cnt_r) begin
      best_cnt_next_s = match_cnt_s;
      best_cls_next_s = k_r;
    end else begin
      best_cnt_next_s = best_cnt_r;
      best_cls_next_s = best_cls_r;
    end
  end

  // Label capture; a channel is only ready until it has delivered, so nothing is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbl_r <= '0;
    end else begin
      for (int i = 0; i < N_CLASSIFIERS; i++) begin
        if (hs_s[i]) begin
          lbl_r[i*LABEL_BITS +: LABEL_BITS] <= axis.s_axis_tdata[i*DATA_WIDTH +: LABEL_BITS];
        end
      end
    end
  end

  // Collect / vote sweep / hold-result state machine with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= COLLECT;
      captured_r <= '0;
      k_r        <= '0;
      best_cnt_r <= '0;
      best_cls_r <= '0;
      tdata_r    <= '0;
      tvalid_r   <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          captured_r <= captured_next_s;
          if (&captured_next_s) begin
            state_r <= VOTE;
          end else begin
            state_r <= COLLECT;
          end
        end
        VOTE: begin
          best_cnt_r <= best_cnt_next_s;
          best_cls_r <= best_cls_next_s;
          if (k_r == LAST_K) begin
            state_r  <= OUTPUT;
            tvalid_r <= 1'b1;
            tdata_r  <= pack_result(best_cls_next_s, CNT_BITS'(best_cnt_next_s), N_VOTERS);
          end else begin
            k_r <= k_r + LABEL_BITS'(1);
          end
        end
        OUTPUT: begin
          if (tvalid_r && axis.m_axis_tready) begin
            state_r    <= COLLECT;
            captured_r <= '0;
            k_r        <= '0;
            best_cnt_r <= '0;
            best_cls_r <= '0;
            tdata_r    <= '0;
            tvalid_r   <= 1'b0;
          end else begin
            state_r <= OUTPUT;
          end
        end
        default: begin
          state_r    <= COLLECT;
          captured_r <= '0;
          k_r        <= '0;
          tvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Result and disagreement counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count_r   <= 32'd0;
      disagree_count_r <= 32'd0;
    end else if (out_hs_s) begin
      result_count_r <= result_count_r + 32'd1;
      if (!tdata_r[UNANIMOUS_BIT]) begin
        disagree_count_r <= disagree_count_r + 32'd1;
      end else begin
        disagree_count_r <= disagree_count_r;
      end
    end else begin
      result_count_r   <= result_count_r;
      disagree_count_r <= disagree_count_r;
    end
  end

endmodule

// File: doc/ensemble_vote_combiner.md
# ensemble_vote_combiner

Parametrised majority-vote combiner for the classifier ensemble. It takes the per-sample label streams from N_CLASSIFIERS HLS classifier cores (one AXI-Stream result beat per classifier per sample) and collects exactly one label from each channel. It then resolves the majority class over a deterministic NUM_CLASSES-cycle vote sweep and emits one fused result beat downstream. It sits between the ensemble wrapper's classifier outputs and the DMA/result sink.

## Interface
Parameters:
- N_CLASSIFIERS, 3, number of voting channels (2..15)
- NUM_CLASSES, 4, number of legal labels (2..256); labels ≥ NUM_CLASSES are invalid votes
- DATA_WIDTH, 32, stream data width (fixed 32)
- KEEP_WIDTH, 4, DATA_WIDTH/8

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  N_CLASSIFIERS*DATA_WIDTH  channel i label in slice [i*DATA_WIDTH +: DATA_WIDTH]; only bits [7:0] are compared, upper bits are ignored
- s_axis_tvalid  in  N_CLASSIFIERS  per-channel valid
- s_axis_tready  out  N_CLASSIFIERS  per-channel ready
- s_axis_tlast  in  N_CLASSIFIERS  ignored; every beat is one sample result
- m_axis_tdata  out  DATA_WIDTH  fused result (format below)
- m_axis_tkeep  out  KEEP_WIDTH  all ones
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  constant 1 whenever tvalid
- result_count  out  32  results accepted downstream, wraps
- disagree_count  out  32  results that were not unanimous, wraps

## Operation
- FSM states: COLLECT, VOTE, OUTPUT.
- COLLECT:
  - s_axis_tready[i] = !captured[i].
  - A handshake on channel i latches the label into lbl[i] and sets captured[i].
  - Channels are captured independently, in any order, in the same or different cycles.
  - When all captured bits are set, including captures completing in this cycle, the next state is VOTE.
- VOTE:
  - All s_axis_tready are 0.
  - Class index k steps 0..NUM_CLASSES-1, one per cycle.
  - cnt = popcount over i of (lbl[i][7:0] == k).
  - If cnt > best_cnt, then best_cnt ← cnt and best_cls ← k. The strict compare makes a tie resolve to the lowest class index.
  - Out-of-range labels never match any k.
  - After k = NUM_CLASSES-1, go to OUTPUT.
- OUTPUT:
  - m_axis_tvalid = 1; tdata is held stable until the handshake.
  - On tvalid & tready: clear captured, best_cnt and best_cls, and k.
  - result_count increments. disagree_count increments if bit31 = 0.
  - Return to COLLECT.
- m_axis_tdata format:
  - [7:0] best_cls
  - [15:8] 0
  - [19:16] best_cnt
  - [29:20] 0
  - [30] no_valid: best_cnt == 0, with best_cls = 0
  - [31] unanimous: best_cnt == N_CLASSIFIERS
- Vote counts fit in 4 bits. Counter width is $clog2(N_CLASSIFIERS+1).

## Timing
- Reset values:
  - state COLLECT, captured all 0
  - s_axis_tready all 1 (combinational, from captured)
  - m_axis_tvalid 0, m_axis_tdata 0
  - m_axis_tkeep all ones, m_axis_tlast 0
  - result_count 0, disagree_count 0
- Latency: last channel captured in cycle t → VOTE cycles t+1..t+NUM_CLASSES → m_axis_tvalid high from t+NUM_CLASSES+1.
- Minimum period per sample: NUM_CLASSES+2 cycles with tready held high.
- A channel that already delivered holds tready low, so extra beats back-pressure and are never dropped or overwritten.
- Backpressure: OUTPUT lasts indefinitely. No new labels are captured until the result handshake.
- Reset mid-operation: all partial captures and any pending result are discarded.
- The counters update in the cycle after the m-handshake and wrap from 0xFFFFFFFF to 0.

## Structure
- Package ensemble_pkg:
  - state enum {COLLECT, VOTE, OUTPUT}
  - result field bit-position constants (CLS_LSB, CNT_LSB, NOVALID_BIT, UNANIMOUS_BIT)
  - LABEL_BITS = 8
- Sub-module vote_popcount (N_CLASSIFIERS labels, class k → match count).
- The FSM, capture registers and counters live in the top.

## Test plan
- Labels {2,2,1}, arriving in the same cycle, NUM_CLASSES=4 → tdata = 0x0002_0002 at capture cycle + 5; disagree_count = 1.
- Labels {3,3,3} arriving in cycles 0, 4, 9 → tready[0] low from cycle 1 until the result handshake; tdata = 0x8003_0003; result_count = 1.
- Labels {0,1,2} (tie) → best_cls 0, cnt 1, tdata = 0x0001_0000.
- Labels {7,9,200} with NUM_CLASSES=4 → tdata = 0x4000_0000 (no_valid).
- m_axis_tready held low 20 cycles with a second sample offered → tdata stable; s_axis_tready all 0 for the already-captured channels; the second sample is accepted only after the handshake.
- rst_n pulsed low after two of three captures → all outputs return to reset values; the next full sample votes without stale labels.
